axis_downsizer: RTL and testbench

//  Width down-converter: accepts one wide word (RATIO narrow slices) per transfer, emits it as RATIO

---
 rtl/axis_downsizer.sv | 125 ++++++++++++
 tb/tb_axis_downsizer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_downsizer.sv
// axis_downsizer - splits each WIDTH*RATIO input word into RATIO WIDTH-bit output transfers.
// Define AXIS_DOWNSIZER_MSB_FIRST_EN to emit the most significant slice first.
module axis_downsizer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [WIDTH*RATIO-1:0]     idata,
  input  logic                       ilast,
  input  logic                       ivalid,
  output logic                       iready,
  output logic [WIDTH-1:0]           odata,
  output logic                       olast,
  output logic                       ovalid,
  input  logic                       oready,
  output logic [$clog2(RATIO)-1:0]   phase
);

  localparam int WW = WIDTH * RATIO;
  localparam int PW = $clog2(RATIO);
  localparam logic [PW-1:0] LAST_CNT = PW'(RATIO - 1);

  logic              r_ovalid;
  logic              r_olast;
  logic [WIDTH-1:0]  r_odata;
  logic [PW-1:0]     r_phase;
  logic [PW-1:0]     r_remaining;
  logic              r_last;
  logic [WW-1:0]     r_shift;
  logic              r_iready;
  logic [WW-1:0]     r_buf_data;
  logic              r_buf_last;

  logic              w_free;
  logic              w_accept;
  logic              w_take_shift;
  logic              w_take_buf;
  logic              w_take_in;
  logic              w_capture;
  logic [WW-1:0]     w_src;
  logic              w_src_last;
  logic [WIDTH-1:0]  w_shift_slice;
  logic [WW-1:0]     w_shift_next;
  logic [WIDTH-1:0]  w_src_slice;
  logic [WW-1:0]     w_src_next;

  assign w_free       = !r_ovalid || oready;
  assign w_accept     = ivalid && r_iready;
  assign w_take_shift = w_free && (r_remaining != '0);
  assign w_take_buf   = w_free && (r_remaining == '0) && !r_iready;
  assign w_take_in    = w_free && (r_remaining == '0) && r_iready && w_accept;
  assign w_capture    = w_accept && !w_take_in;

  // A full buffer always wins over the input, and iready is low then anyway.
  assign w_src      = r_iready ? idata : r_buf_data;
  assign w_src_last = r_iready ? ilast : r_buf_last;

`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
  assign w_shift_slice = r_shift[WW-1 -: WIDTH];
  assign w_shift_next  = r_shift << WIDTH;
  assign w_src_slice   = w_src[WW-1 -: WIDTH];
  assign w_src_next    = w_src << WIDTH;
`else
  assign w_shift_slice = r_shift[WIDTH-1:0];
  assign w_shift_next  = r_shift >> WIDTH;
  assign w_src_slice   = w_src[WIDTH-1:0];
  assign w_src_next    = w_src >> WIDTH;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovalid    <= 1'b0;
      r_olast     <= 1'b0;
      r_phase     <= '0;
      r_remaining <= '0;
      r_last      <= 1'b0;
      r_iready    <= 1'b1;
    end else begin
      if (w_take_shift) begin
        r_ovalid    <= 1'b1;
        r_remaining <= r_remaining - PW'(1);
        r_phase     <= r_phase + PW'(1);
        r_olast     <= r_last && (r_remaining == PW'(1));
      end else if (w_take_buf || w_take_in) begin
        r_ovalid    <= 1'b1;
        r_remaining <= LAST_CNT;
        r_phase     <= '0;
        r_last      <= w_src_last;
        r_olast     <= 1'b0;
      end else if (w_free) begin
        r_ovalid    <= 1'b0;
        r_olast     <= 1'b0;
      end

      if (w_capture) begin
        r_iready <= 1'b0;
      end else if (w_take_buf) begin
        r_iready <= 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; valid/remaining qualify them.
  always_ff @(posedge clock) begin
    if (w_take_shift) begin
      r_odata <= w_shift_slice;
      r_shift <= w_shift_next;
    end else if (w_take_buf || w_take_in) begin
      r_odata <= w_src_slice;
      r_shift <= w_src_next;
    end
    if (w_capture) begin
      r_buf_data <= idata;
      r_buf_last <= ilast;
    end
  end

  assign iready = r_iready;
  assign odata  = r_odata;
  assign olast  = r_olast;
  assign ovalid = r_ovalid;
  assign phase  = r_phase;

endmodule

// File: tb/tb_axis_downsizer.sv
// tb/tb_axis_downsizer.sv - self-checking bench for axis_downsizer (WIDTH=8, RATIO=4).
module tb_axis_downsizer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] idata = '0;
  logic        ilast = 1'b0;
  logic        ivalid = 1'b0;
  logic        iready;
  logic [7:0]  odata;
  logic        olast;
  logic        ovalid;
  logic        oready = 1'b0;
  logic [1:0]  phase;

  axis_downsizer #(.WIDTH(8), .RATIO(4)) dut (
    .clock(clock), .resetn(resetn),
    .idata(idata), .ilast(ilast), .ivalid(ivalid), .iready(iready),
    .odata(odata), .olast(olast), .ovalid(ovalid), .oready(oready),
    .phase(phase)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [1:0] p;
  } slice_t;
  slice_t q[$];

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        il;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic [1:0]  ep;
    logic        er;
  } vec_t;
  vec_t vecs[16];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;
  logic [1:0] prev_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slice i of a wide word, computed directly from the ordering rule.
  function automatic logic [7:0] sl(input logic [31:0] w, input int i);
    logic [31:0] t;
`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
    t = w >> (8 * (3 - i));
`else
    t = w >> (8 * i);
`endif
    return t[7:0];
  endfunction

  function automatic void push_word(input logic [31:0] w, input logic l);
    for (int i = 0; i < 4; i++) begin
      slice_t s;
      s.d = sl(w, i);
      s.l = l && (i == 3);
      s.p = 2'(i);
      q.push_back(s);
    end
  endfunction

  task automatic cycle(input logic iv, input logic [31:0] id, input logic il, input logic ordy);
    slice_t s;
    @(negedge clock);
    ivalid = iv; idata = id; ilast = il; oready = ordy;
    #1;
    if (prev_stall) begin
      chk("hold_ovalid", {31'b0, ovalid}, 32'd1);
      chk("hold_odata", {24'b0, odata}, {24'b0, prev_d});
      chk("hold_olast", {31'b0, olast}, {31'b0, prev_l});
      chk("hold_phase", {30'b0, phase}, {30'b0, prev_p});
    end
    if (ovalid && oready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {31'b0, ovalid}, 32'd0);
      end else begin
        s = q.pop_front();
        chk("sb_odata", {24'b0, odata}, {24'b0, s.d});
        chk("sb_olast", {31'b0, olast}, {31'b0, s.l});
        chk("sb_phase", {30'b0, phase}, {30'b0, s.p});
      end
    end
    if (ivalid && iready) push_word(id, il);
    prev_stall = ovalid && !oready;
    prev_d = odata; prev_l = olast; prev_p = phase;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; ivalid = 1'b0; oready = 1'b0; ilast = 1'b0; idata = '0;
    repeat (3) begin
      @(negedge clock); #1;
      chk("rst_ovalid", {31'b0, ovalid}, 32'd0);
      chk("rst_olast", {31'b0, olast}, 32'd0);
      chk("rst_iready", {31'b0, iready}, 32'd1);
      chk("rst_phase", {30'b0, phase}, 32'd0);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("post_rst_ovalid", {31'b0, ovalid}, 32'd0);
    chk("post_rst_iready", {31'b0, iready}, 32'd1);
    chk("post_rst_phase", {30'b0, phase}, 32'd0);
    q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic drain();
    repeat (14) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_q_empty", q.size(), 32'd0);
    chk("drain_ovalid", {31'b0, ovalid}, 32'd0);
  endtask

  initial begin
    logic [31:0] wa;
    logic [31:0] wb;
    logic        pending;
    logic        riv;
    logic [31:0] rd;
    logic        rl;
    logic        rr;

    wa = 32'h44332211;
    wb = 32'hDDCCBBAA;

    do_reset();

    // Single word, then two back-to-back words, cycle by cycle.
    vecs[0]  = '{1'b1, wa, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 0), 1'b0, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 1), 1'b0, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 2), 1'b0, 2'd2, 1'b1};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 3), 1'b1, 2'd3, 1'b1};
    vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vecs[6]  = '{1'b1, wb, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vecs[7]  = '{1'b1, wa, 1'b1, 1'b1, 1'b1, sl(wb, 0), 1'b0, 2'd0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wb, 1), 1'b0, 2'd1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wb, 2), 1'b0, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wb, 3), 1'b0, 2'd3, 1'b0};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 0), 1'b0, 2'd0, 1'b1};
    vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 1), 1'b0, 2'd1, 1'b1};
    vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 2), 1'b0, 2'd2, 1'b1};
    vecs[14] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, sl(wa, 3), 1'b1, 2'd3, 1'b1};
    vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      ivalid = vecs[i].iv; idata = vecs[i].id; ilast = vecs[i].il; oready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_ovalid", i), {31'b0, ovalid}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d_olast", i), {31'b0, olast}, {31'b0, vecs[i].el});
      chk($sformatf("vec%0d_iready", i), {31'b0, iready}, {31'b0, vecs[i].er});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_odata", i), {24'b0, odata}, {24'b0, vecs[i].ed});
        chk($sformatf("vec%0d_phase", i), {30'b0, phase}, {30'b0, vecs[i].ep});
      end
    end

    // Stall after the first slice while a second word arrives.
    do_reset();
    cycle(1'b1, wb, 1'b0, 1'b1);
    cycle(1'b1, wa, 1'b1, 1'b0);
    chk("stall_first_slice", {24'b0, odata}, {24'b0, sl(wb, 0)});
    repeat (4) begin
      cycle(1'b1, wa, 1'b1, 1'b0);
      chk("stall_iready", {31'b0, iready}, 32'd0);
    end
    drain();

    // Continuous input with oready high: no bubbles between words.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, $urandom, 1'(i % 2), 1'b1);
      if (i >= 1) chk($sformatf("thru_ovalid%0d", i), {31'b0, ovalid}, 32'd1);
    end
    drain();

    // Reset mid-word with a buffered word pending.
    do_reset();
    cycle(1'b1, wa, 1'b1, 1'b1);
    cycle(1'b1, wb, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("midrst_phase_before", {30'b0, phase}, 32'd2);
    chk("midrst_iready_before", {31'b0, iready}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("midrst_ovalid", {31'b0, ovalid}, 32'd0);
    chk("midrst_iready", {31'b0, iready}, 32'd1);
    chk("midrst_phase", {30'b0, phase}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    q.delete();
    prev_stall = 1'b0;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("midrst_idle", {31'b0, ovalid}, 32'd0);
    cycle(1'b1, 32'h87654321, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("midrst_new_phase", {30'b0, phase}, 32'd0);
    chk("midrst_new_odata", {24'b0, odata}, {24'b0, sl(32'h87654321, 0)});
    drain();

    // Randomized traffic against the scoreboard; upstream holds a word until accepted.
    do_reset();
    pending = 1'b0;
    riv = 1'b0; rd = '0; rl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pending) begin
        riv = ($urandom_range(0, 9) < 7);
        rd  = $urandom;
        rl  = 1'($urandom_range(0, 1));
      end
      rr = ($urandom_range(0, 9) < 6);
      cycle(riv, rd, rl, rr);
      pending = riv && !iready;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
